// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache: instruction cache between the datapath fetch port and the memory
// controller read port. It is direct-mapped with one-word lines and blocks
// the fetch while a miss is being filled.
//
// Lookups are combinational. A hit returns ihit/imemload in the same cycle.
// A miss latches the word address and enters FETCH. FETCH holds iREN until
// iwait drops, then writes the line.
//
// Parameters
//   SETS        number of lines (power of 2, >= 2)
// Ports
//   CLK, nRST   clock (rising edge), asynchronous active-low reset
//   imemREN     datapath fetch request
//   imemaddr    fetch byte address (bits [1:0] ignored)
//   ihit        fetch satisfied this cycle, imemload valid
//   imemload    instruction word
//   flush       synchronous invalidate of all lines
//   iREN/iaddr  memory read request / word-aligned address
//   iwait       memory busy; iload valid when low while iREN=1
//   iload       memory read data
//   hit_count   lookups that hit         (ICACHE_STATS_EN only)
//   miss_count  misses that began a fill (ICACHE_STATS_EN only)
// Build option: define ICACHE_STATS_EN to add the saturating hit/miss
// counters.
// ---------------------------------------------------------------------------
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS];
  logic [31:0]        r_fill_addr;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill_we;
  logic               w_unused;

  // Byte offset of the fetch address plays no part in lookup
  assign w_unused   = ^imemaddr[1:0];

  assign w_idx      = imemaddr[2+IDX_W-1:2];
  assign w_tag      = imemaddr[31:2+IDX_W];
  assign w_fill_idx = r_fill_addr[2+IDX_W-1:2];
  assign w_fill_tag = r_fill_addr[31:2+IDX_W];

  assign w_hit = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and outputs; iREN/iaddr depend only on state (Moore), so
  // async reset drops them immediately
  always_comb begin
    w_next    = r_state;
    ihit      = 1'b0;
    imemload  = 32'h0;
    iREN      = 1'b0;
    iaddr     = 32'h0;
    w_miss    = 1'b0;
    w_fill_we = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          ihit     = 1'b1;
          imemload = r_data[w_idx];
        end else if (imemREN) begin
          w_miss = 1'b1;
          w_next = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = r_fill_addr;
        if (!iwait) begin
          w_fill_we = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the word-aligned miss address; the fill always targets it
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_fill_addr <= 32'h0;
    else if (w_miss) r_fill_addr <= {imemaddr[31:2], 2'b00};
  end

  // Valid bits: flush beats a coincident fill, so that line stays invalid
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          r_valid <= '0;
    else if (flush)     r_valid <= '0;
    else if (w_fill_we) r_valid[w_fill_idx] <= 1'b1;
  end

  // Tag/data arrays need no reset; valid bits gate every use
  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic w_hit_evt;
  assign w_hit_evt = (r_state == IDLE) & w_hit;

  // Saturating counters, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (w_hit_evt && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (w_miss && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
